bitslip_ctrl: RTL

Parametrised multi-channel ISERDES word-alignment controller, the successor to the single-lane frame-clock aligner. Each of NUM_CH channels compares its deserialised frame word against a programmable pattern. It issues one-cycle bitslip pulses spaced by a settle interval until the pattern is confirmed over several consecutive words, then keeps monitoring for loss of lock. It sits between the ADC ISERDES bank and the capture logic, in the CLKDIV domain, and adds bounded retry with a failure flag, lock confirmation, loss-of-lock re-acquisition and a software restart.

---
 rtl/bitslip_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bitslip_ctrl.sv
// Multi-channel ISERDES word aligner: per-channel bitslip search against a frame
// pattern with lock confirmation, loss-of-lock re-acquisition and bounded retry.
module bitslip_ctrl #(
   parameter int unsigned        DATA_W     = 8,
   parameter int unsigned        NUM_CH     = 1,
   parameter logic [DATA_W-1:0]  PATTERN    = DATA_W'(8'hF0),
   parameter int unsigned        SETTLE_CYC = 8,
   parameter int unsigned        LOCK_CNT   = 4,
   parameter int unsigned        LOSS_CNT   = 4,
   parameter int unsigned        MAX_SLIPS  = 2*DATA_W
) (
   input  logic                     CLKDIV,
   input  logic                     rst_n,
   input  logic                     restart,
   input  logic [NUM_CH*DATA_W-1:0] ISERDES_FCO,
   output logic [NUM_CH-1:0]        ISERDES_bslip,
   output logic [NUM_CH-1:0]        aligned,
   output logic [NUM_CH-1:0]        fail,
   output logic                     all_aligned
);

   localparam int unsigned SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int unsigned SLIP_W   = $clog2(MAX_SLIPS + 1);
   localparam int unsigned CNT_W    = 4;

   typedef enum logic [2:0] {
      ST_STARTUP = 3'd0,
      ST_POLL    = 3'd1,
      ST_SLIP    = 3'd2,
      ST_CONFIRM = 3'd3,
      ST_LOCKED  = 3'd4,
      ST_FAIL    = 3'd5
   } state_t;

   logic [NUM_CH-1:0] aligned_nx;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_t              state_q, state_d;
      logic [SETTLE_W-1:0] settle_q, settle_d;
      logic [SLIP_W-1:0]   slip_q, slip_d;
      logic [CNT_W-1:0]    cnt_q, cnt_d;
      logic                bslip_d, bslip_q, aligned_q, fail_q;
      logic [DATA_W-1:0]   word;
      logic                hit;

      assign word = ISERDES_FCO[c*DATA_W +: DATA_W];
      assign hit  = (word == PATTERN);

      // State, counters and next-state-decoded outputs
      always_ff @(posedge CLKDIV or negedge rst_n) begin
         if (!rst_n) begin
            state_q   <= ST_STARTUP;
            settle_q  <= '0;
            slip_q    <= '0;
            cnt_q     <= '0;
            bslip_q   <= 1'b0;
            aligned_q <= 1'b0;
            fail_q    <= 1'b0;
         end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            slip_q    <= slip_d;
            cnt_q     <= cnt_d;
            bslip_q   <= bslip_d;
            aligned_q <= (state_d == ST_LOCKED);
            fail_q    <= (state_d == ST_FAIL);
         end
      end

      // cnt_q counts matches in CONFIRM and misses in LOCKED
      always_comb begin
         state_d  = state_q;
         settle_d = settle_q;
         slip_d   = slip_q;
         cnt_d    = cnt_q;
         bslip_d  = 1'b0;
         if (restart) begin
            state_d  = ST_STARTUP;
            settle_d = '0;
            slip_d   = '0;
            cnt_d    = '0;
         end else begin
            case (state_q)
               ST_STARTUP: begin
                  if (settle_q == SETTLE_W'(SETTLE_CYC - 1)) begin
                     state_d  = ST_POLL;
                     settle_d = '0;
                  end else begin
                     settle_d = settle_q + SETTLE_W'(1);
                  end
               end
               ST_POLL: begin
                  if (hit) begin
                     if (LOCK_CNT == 1) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                     end else begin
                        state_d = ST_CONFIRM;
                        cnt_d   = CNT_W'(1);
                     end
                  end else if (slip_q >= SLIP_W'(MAX_SLIPS)) begin
                     state_d = ST_FAIL;
                  end else begin
                     state_d  = ST_SLIP;
                     slip_d   = slip_q + SLIP_W'(1);
                     settle_d = '0;
                     bslip_d  = 1'b1;
                  end
               end
               ST_SLIP: begin
                  if (settle_q == SETTLE_W'(SETTLE_CYC - 1)) begin
                     state_d  = ST_POLL;
                     settle_d = '0;
                  end else begin
                     settle_d = settle_q + SETTLE_W'(1);
                  end
               end
               ST_CONFIRM: begin
                  if (!hit) begin
                     state_d = ST_POLL;
                     cnt_d   = '0;
                  end else if (cnt_q >= CNT_W'(LOCK_CNT - 1)) begin
                     state_d = ST_LOCKED;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               ST_LOCKED: begin
                  if (hit) begin
                     cnt_d = '0;
                  end else if (cnt_q >= CNT_W'(LOSS_CNT - 1)) begin
                     state_d = ST_POLL;
                     cnt_d   = '0;
                     slip_d  = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               ST_FAIL: ;
               default: begin
                  state_d  = ST_STARTUP;
                  settle_d = '0;
                  slip_d   = '0;
                  cnt_d    = '0;
               end
            endcase
         end
      end

      assign aligned_nx[c]    = (state_d == ST_LOCKED);
      assign ISERDES_bslip[c] = bslip_q;
      assign aligned[c]       = aligned_q;
      assign fail[c]          = fail_q;
   end

   // Registered AND of per-channel lock, aligned with the per-channel flags
   always_ff @(posedge CLKDIV or negedge rst_n) begin
      if (!rst_n) begin
         all_aligned <= 1'b0;
      end else begin
         all_aligned <= &aligned_nx;
      end
   end

endmodule
